numerical_derivative: RTL
=========================

Name: numerical_derivative

Overview:
Streaming backward-difference differentiator, the inverse of the numericalIntegral block. Takes fixed-point samples (milli-units, scale 1e-3) such as height and produces the per-sample rate of change, e.g. velocity recovered from integrated height. Used to cross-check getVelocity against numericalIntegral output, and to derive velocity from altitudeCalculator altitude after gimbal start. One sample in, one registered result out; fully synchronous.

Parameters:
N, 64, data width of input and outputs; two's-complement signed.
DT_LOG2, 0, sample period as a power of two; difference is arithmetic-shifted right by DT_LOG2.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
start_derivation  input  1  level enable; low forces IDLE.
sample_valid  input  1  signal_input is valid this cycle.
signal_input  input  N  signed sample, milli-units.
derivative_result  output  N  signed first difference, saturated.
result_valid  output  1  one-cycle pulse; derivative_result updated this cycle.
primed  output  1  history register holds a valid sample.
overflow  output  1  sticky; a result saturated since the last IDLE entry.

Behaviour:
- Reset: sampled on a rising clk edge while reset=1. All state cleared: state=IDLE, prev=0, derivative_result=0, result_valid=0, primed=0, overflow=0. Reset overrides every other input, including mid-operation.
- States:
  - IDLE:
    - Samples ignored; outputs hold. derivative_result keeps its last value; result_valid=0.
    - start_derivation=1 -> PRIME.
    - Entering IDLE clears prev, primed and overflow. derivative_result is not cleared.
  - PRIME:
    - First cycle with sample_valid=1: prev<=signal_input, primed<=1, -> RUN.
    - No result is produced.
  - RUN, on each sample_valid=1:
    - diff = sext(signal_input) - sext(prev), computed at N+1 bits.
    - q = diff >>> DT_LOG2 (arithmetic; rounds toward -inf).
    - Saturate q to the signed N-bit range [-2^(N-1), 2^(N-1)-1]. overflow<=1 if clamped.
    - derivative_result<=q, result_valid<=1 at the next edge (latency 1 cycle from the accepting edge).
    - prev<=signal_input.
    - sample_valid=0: result_valid<=0, all else holds.
  - Any state, start_derivation=0 -> IDLE at the next edge. It takes priority over a simultaneous sample_valid, and that sample is dropped.
- Back-to-back samples, one per cycle, give one result per cycle. No stall and no backpressure; the consumer must capture on result_valid.
- Gapped samples: the difference is against the last accepted sample, regardless of idle cycles in between.
- result_valid is never high in IDLE or PRIME, or in the cycle after leaving RUN.
- Equal consecutive samples give result 0, not a hold.

Optional Feature:
Macro: NUMERICAL_DERIVATIVE_SECOND_EN.
- Defined:
  - Adds output second_result [N-1:0] (signed second difference) and a second history register prev2.
  - Adds state PRIME2 between PRIME and RUN. The second sample moves to RUN and produces the first derivative_result with result_valid=1; second_result is held at 0 for that sample.
  - From the third sample on: second_result = sat((x - 2*prev + prev2) >>> (2*DT_LOG2)), computed at N+2 bits. It updates in the same cycle as derivative_result, and saturation also sets overflow.
  - IDLE entry clears prev2. Reset clears second_result to 0.
- Undefined: no second_result port, no PRIME2 state, no prev2 register.

Test Plan:
- Reset and prime: reset=1 for 2 cycles, then start=1, samples 1000, 3000 -> all outputs 0 after reset; primed=1 after the first sample; result_valid pulses once, one cycle after the 3000 edge, with derivative_result=2000.
- Ramp streaming: samples 0, 9799, 19598, 29397 on consecutive cycles, DT_LOG2=0 -> three consecutive pulses, each derivative_result=9799, overflow=0.
- Negative and shift: DT_LOG2=2, samples 100 then 90 -> diff=-10, derivative_result=-3 (rounds toward -inf).
- Saturation: N=64, samples -2^63 then 2^63-1 -> derivative_result=2^63-1, overflow=1 (sticky). start=0 -> overflow=0.
- Simultaneous stop: start drops in the same cycle as sample_valid=1 -> no result_valid pulse, state IDLE, primed=0. Restart requires a fresh prime with no result on the first sample.
- Reset mid-RUN: assert reset between samples -> next edge all outputs 0. The following sample after start does not produce a result.

Source files
------------

// File: rtl/numerical_derivative.sv
// Streaming backward-difference differentiator with saturation and sticky overflow.
// Optional second difference output: define NUMERICAL_DERIVATIVE_SECOND_EN.
module numerical_derivative #(
    parameter int N       = 64,
    parameter int DT_LOG2 = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_derivation,
    input  logic         sample_valid,
    input  logic [N-1:0] signal_input,
    output logic [N-1:0] derivative_result,
    output logic         result_valid,
    output logic         primed,
`ifdef NUMERICAL_DERIVATIVE_SECOND_EN
    output logic [N-1:0] second_result,
`endif
    output logic         overflow
);

`ifdef NUMERICAL_DERIVATIVE_SECOND_EN
    typedef enum logic [1:0] {
        S_IDLE, S_PRIME, S_PRIME2, S_RUN
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_PRIME, S_RUN
    } state_t;
`endif

    state_t       state_q;
    logic [N-1:0] prev_q;
    logic [N-1:0] result_q;
    logic         valid_q;
    logic         primed_q;
    logic         ovf_q;

    logic signed [N:0] diff1;
    logic signed [N:0] q1;
    logic              ovf1_d;
    logic [N-1:0]      sat1_d;

    // One extra bit holds any N-bit difference; the top two bits disagree only
    // when the shifted value no longer fits back into N bits.
    always_comb begin
        diff1  = $signed({signal_input[N-1], signal_input})
               - $signed({prev_q[N-1], prev_q});
        q1     = diff1 >>> DT_LOG2;
        ovf1_d = q1[N] ^ q1[N-1];
        sat1_d = ovf1_d ? {q1[N], {(N-1){~q1[N]}}} : q1[N-1:0];
    end

`ifdef NUMERICAL_DERIVATIVE_SECOND_EN
    logic [N-1:0]        prev2_q;
    logic [N-1:0]        second_q;
    logic signed [N+1:0] diff2;
    logic signed [N+1:0] q2;
    logic                ovf2_d;
    logic [N-1:0]        sat2_d;

    always_comb begin
        diff2  = $signed({{2{signal_input[N-1]}}, signal_input})
               - $signed({prev_q[N-1], prev_q, 1'b0})
               + $signed({{2{prev2_q[N-1]}}, prev2_q});
        q2     = diff2 >>> (2 * DT_LOG2);
        ovf2_d = (q2[N+1:N-1] != 3'b000) && (q2[N+1:N-1] != 3'b111);
        sat2_d = ovf2_d ? {q2[N+1], {(N-1){~q2[N+1]}}} : q2[N-1:0];
    end

    assign second_result = second_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            prev_q   <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            primed_q <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef NUMERICAL_DERIVATIVE_SECOND_EN
            prev2_q  <= '0;
            second_q <= '0;
`endif
        end else if (!start_derivation) begin
            // Stop wins over a coincident sample; the result register is kept.
            state_q  <= S_IDLE;
            prev_q   <= '0;
            valid_q  <= 1'b0;
            primed_q <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef NUMERICAL_DERIVATIVE_SECOND_EN
            prev2_q  <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: state_q <= S_PRIME;
                S_PRIME: begin
                    if (sample_valid) begin
                        prev_q   <= signal_input;
                        primed_q <= 1'b1;
`ifdef NUMERICAL_DERIVATIVE_SECOND_EN
                        state_q  <= S_PRIME2;
`else
                        state_q  <= S_RUN;
`endif
                    end
                end
`ifdef NUMERICAL_DERIVATIVE_SECOND_EN
                S_PRIME2: begin
                    if (sample_valid) begin
                        result_q <= sat1_d;
                        valid_q  <= 1'b1;
                        ovf_q    <= ovf_q | ovf1_d;
                        second_q <= '0;
                        prev2_q  <= prev_q;
                        prev_q   <= signal_input;
                        state_q  <= S_RUN;
                    end
                end
`endif
                S_RUN: begin
                    if (sample_valid) begin
                        result_q <= sat1_d;
                        valid_q  <= 1'b1;
                        prev_q   <= signal_input;
`ifdef NUMERICAL_DERIVATIVE_SECOND_EN
                        ovf_q    <= ovf_q | ovf1_d | ovf2_d;
                        second_q <= sat2_d;
                        prev2_q  <= prev_q;
`else
                        ovf_q    <= ovf_q | ovf1_d;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign derivative_result = result_q;
    assign result_valid      = valid_q;
    assign primed            = primed_q;
    assign overflow          = ovf_q;

endmodule
